// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the external device bus.
// Software programs PRESET and CTRL; the FSM loads COUNT from PRESET,
// counts down to zero and raises a pending flag that drives IRQ when unmasked.
module timer_dev #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [3:0]  byteen,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  state_t      state;
  state_t      next_state;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pend;

  logic        match;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;

  logic        en;
  logic        im;
  logic        auto_reload;

  logic        load_count;
  logic        dec_count;
  logic        set_pend;
  logic        drop_pend;
  logic        clr_en;

  // Byte offset bits are meaningless for word-only registers.
  logic [1:0]  unused_addr;
  assign unused_addr = Addr[1:0];

  // Only full-word writes inside our 16-byte window are honoured.
  assign match     = (Addr[31:4] == BASE[31:4]);
  assign wr        = WE & match & (byteen == 4'hF);
  assign wr_ctrl   = wr & (Addr[3:2] == OFF_CTRL);
  assign wr_preset = wr & (Addr[3:2] == OFF_PRESET);

  // MODE 1x deliberately falls back to one-shot behaviour.
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign im          = ctrl[3];

  // Both operands are flops, so the interrupt line never sees the bus directly.
  assign IRQ = pend & im;

  // State register for the countdown sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-state action strobes for the datapath registers.
  always_comb begin
    next_state = state;
    load_count = 1'b0;
    dec_count  = 1'b0;
    set_pend   = 1'b0;
    drop_pend  = 1'b0;
    clr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        load_count = 1'b1;
        if (en) begin
          next_state = S_CNT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_CNT: begin
        if (!en) begin
          next_state = S_IDLE;
        end else if (count == 32'd0) begin
          next_state = S_INT;
          set_pend   = 1'b1;
        end else begin
          dec_count = 1'b1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          next_state = S_LOAD;
          drop_pend  = 1'b1;
        end else begin
          next_state = S_IDLE;
          clr_en     = 1'b1;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // CTRL: a bus write takes priority over the one-shot EN auto-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 4'h0;
    end else if (wr_ctrl) begin
      ctrl <= Din[3:0];
    end else if (clr_en) begin
      ctrl[0] <= 1'b0;
    end
  end

  // PRESET only feeds COUNT at LOAD, so rewriting it mid-count is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (wr_preset) begin
      preset <= Din;
    end
  end

  // COUNT is loaded or decremented only by the FSM; it holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (load_count) begin
      count <= preset;
    end else if (dec_count && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  // Pending flag: the FSM set beats any simultaneous software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (set_pend) begin
      pend <= 1'b1;
    end else if (wr_ctrl || wr_preset || drop_pend) begin
      pend <= 1'b0;
    end
  end

  // Side-effect-free read mux; anything outside our window reads as zero.
  always_comb begin
    Dout = 32'd0;
    if (match) begin
      case (Addr[3:2])
        OFF_CTRL:   Dout = {28'd0, ctrl};
        OFF_PRESET: Dout = preset;
        OFF_COUNT:  Dout = count;
        OFF_RSVD:   Dout = 32'd0;
        default:    Dout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scenario tasks plus randomized runs against an arithmetic
// model that predicts COUNT/IRQ/CTRL from the edge number since enabling.
module tb_timer_dev;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;
  localparam logic [31:0] A_OUTSIDE = BASE + 32'h10;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [3:0]  byteen;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  timer_dev #(.BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WE     (WE),
    .byteen (byteen),
    .Din    (Din),
    .Dout   (Dout),
    .IRQ    (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Model: COUNT at edge e after the enabling write at edge 0.
  function automatic logic [31:0] exp_count(int e, int n, bit auto_mode, logic [31:0] prior);
    int t;
    int ph;
    if (e < 2) return prior;
    t = e - 2;
    if (auto_mode) begin
      ph = t % (n + 3);
      if (ph <= n) return 32'(n - ph);
      return 32'd0;
    end
    if (t <= n) return 32'(n - t);
    return 32'd0;
  endfunction

  // Model: IRQ level at edge e.
  function automatic logic exp_irq(int e, int n, bit auto_mode, bit im);
    int t;
    if (!im || e < 2) return 1'b0;
    t = e - 2;
    if (auto_mode) return ((t % (n + 3)) == n + 1);
    return (t >= n + 1);
  endfunction

  // Model: CTRL readback at edge e (one-shot clears EN after the INT edge).
  function automatic logic [31:0] exp_ctrl(int e, int n, bit auto_mode, logic [31:0] written);
    if (!auto_mode && e >= n + 4) return written & 32'hE;
    return written & 32'hF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Addr   = a;
    Din    = d;
    byteen = be;
    WE     = 1'b1;
    @(posedge clk);
    #1;
    WE     = 1'b0;
    byteen = 4'hF;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = Dout;
  endtask

  task automatic do_reset();
    WE    = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] addrs [4];
    addrs[0] = A_CTRL; addrs[1] = A_PRESET; addrs[2] = A_COUNT; addrs[3] = A_RSVD;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      peek(addrs[i], v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_read off=%0d got %h expected 0", i, v);
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (IRQ !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_irq cycle=%0d got %b expected 0", c, IRQ);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int e = 1; e <= 9; e++) begin
      tick();
      peek(A_COUNT, v);
      n_checks++;
      if (v !== exp_count(e, 3, 1'b0, 32'd0)) begin
        n_fail++;
        $display("[TB] FAIL oneshot_count e=%0d got %0d expected %0d", e, v, exp_count(e, 3, 1'b0, 32'd0));
      end
      n_checks++;
      if (IRQ !== exp_irq(e, 3, 1'b0, 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL oneshot_irq e=%0d got %b expected %b", e, IRQ, exp_irq(e, 3, 1'b0, 1'b1));
      end
      peek(A_CTRL, v);
      n_checks++;
      if (v !== exp_ctrl(e, 3, 1'b0, 32'h9)) begin
        n_fail++;
        $display("[TB] FAIL oneshot_ctrl e=%0d got %h expected %h", e, v, exp_ctrl(e, 3, 1'b0, 32'h9));
      end
    end
    bus_write(A_PRESET, 32'd5, 4'hF);
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL oneshot_irq_clear got %b expected 0", IRQ);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    int pulses;
    pulses = 0;
    do_reset();
    bus_write(A_PRESET, 32'd2, 4'hF);
    bus_write(A_CTRL, 32'hB, 4'hF);
    for (int e = 1; e <= 17; e++) begin
      tick();
      peek(A_COUNT, v);
      n_checks++;
      if (v !== exp_count(e, 2, 1'b1, 32'd0)) begin
        n_fail++;
        $display("[TB] FAIL auto_count e=%0d got %0d expected %0d", e, v, exp_count(e, 2, 1'b1, 32'd0));
      end
      n_checks++;
      if (IRQ !== exp_irq(e, 2, 1'b1, 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL auto_irq e=%0d got %b expected %b", e, IRQ, exp_irq(e, 2, 1'b1, 1'b1));
      end
      if (IRQ === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 3) begin
      n_fail++;
      $display("[TB] FAIL auto_pulse_count got %0d expected 3", pulses);
    end
  endtask

  task automatic test_masked();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd10, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    for (int e = 1; e <= 15; e++) begin
      tick();
      n_checks++;
      if (IRQ !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL masked_irq e=%0d got %b expected 0", e, IRQ);
      end
    end
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL masked_count got %0d expected 0", v);
    end
    bus_write(A_CTRL, 32'h8, 4'hF);
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL masked_unmask_irq got %b expected 0", IRQ);
    end
  endtask

  task automatic test_pause_restart();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd10, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    tick();
    tick();
    bus_write(A_PRESET, 32'd20, 4'hF);
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd9) begin
      n_fail++;
      $display("[TB] FAIL pause_preset_midcount got %0d expected 9", v);
    end
    tick();
    tick();
    bus_write(A_CTRL, 32'h8, 4'hF);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      peek(A_COUNT, v);
      n_checks++;
      if (v !== 32'd6) begin
        n_fail++;
        $display("[TB] FAIL pause_hold c=%0d got %0d expected 6", c, v);
      end
    end
    bus_write(A_CTRL, 32'h9, 4'hF);
    tick();
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd6) begin
      n_fail++;
      $display("[TB] FAIL restart_load_edge got %0d expected 6", v);
    end
    tick();
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd20) begin
      n_fail++;
      $display("[TB] FAIL restart_reload got %0d expected 20", v);
    end
    tick();
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd19) begin
      n_fail++;
      $display("[TB] FAIL restart_count got %0d expected 19", v);
    end
  endtask

  task automatic test_preset_zero();
    do_reset();
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_checks++;
      if (IRQ !== (e >= 3)) begin
        n_fail++;
        $display("[TB] FAIL zero_irq e=%0d got %b expected %b", e, IRQ, (e >= 3));
      end
    end
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd1, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    tick();
    tick();
    tick();
    bus_write(A_PRESET, 32'd7, 4'hF);
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL collide_set_wins got %b expected 1", IRQ);
    end
    bus_write(A_CTRL, 32'h9, 4'hF);
    peek(A_CTRL, v);
    n_checks++;
    if (v !== 32'h9) begin
      n_fail++;
      $display("[TB] FAIL collide_ctrl_wins got %h expected 9", v);
    end
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL collide_pend_cleared got %b expected 0", IRQ);
    end
    tick();
    tick();
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd7) begin
      n_fail++;
      $display("[TB] FAIL collide_reload got %0d expected 7", v);
    end
  endtask

  task automatic test_edge_cases();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'h1234_5678, 4'hF);
    bus_write(A_PRESET, 32'hFFFF_FFFF, 4'b0011);
    peek(A_PRESET, v);
    n_checks++;
    if (v !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL partial_write got %h expected 12345678", v);
    end
    bus_write(A_COUNT, 32'h0000_DEAD, 4'hF);
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL count_write got %h expected 0", v);
    end
    bus_write(A_RSVD, 32'hABCD_0001, 4'hF);
    peek(A_RSVD, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rsvd_read got %h expected 0", v);
    end
    bus_write(A_OUTSIDE, 32'h9, 4'hF);
    peek(A_CTRL, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL outside_write got %h expected 0", v);
    end
    peek(A_OUTSIDE + 32'h4, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL outside_read got %h expected 0", v);
    end
    bus_write(A_CTRL, 32'hFFFF_FFF8, 4'hF);
    peek(A_CTRL, v);
    n_checks++;
    if (v !== 32'h8) begin
      n_fail++;
      $display("[TB] FAIL ctrl_upper_bits got %h expected 8", v);
    end
    bus_write(A_PRESET, 32'd10, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int e = 1; e <= 8; e++) tick();
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd4) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_count got %0d expected 4", v);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    peek(A_COUNT, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_count got %0d expected 0", v);
    end
    peek(A_CTRL, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_ctrl got %h expected 0", v);
    end
    peek(A_PRESET, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_preset got %h expected 0", v);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (IRQ !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midreset_irq c=%0d got %b expected 0", c, IRQ);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] ctrl_val;
    int n;
    int mode;
    bit im;
    bit auto_mode;
    for (int it = 0; it < 20; it++) begin
      n         = int'($urandom_range(0, 12));
      mode      = int'($urandom_range(0, 3));
      im        = 1'($urandom_range(0, 1));
      auto_mode = (mode == 1);
      ctrl_val  = {28'd0, im, 2'(mode), 1'b1};
      do_reset();
      bus_write(A_PRESET, 32'(n), 4'hF);
      bus_write(A_CTRL, ctrl_val, 4'hF);
      for (int e = 1; e <= 3 * (n + 3) + 2; e++) begin
        tick();
        peek(A_COUNT, v);
        n_checks++;
        if (v !== exp_count(e, n, auto_mode, 32'd0)) begin
          n_fail++;
          $display("[TB] FAIL rand_count it=%0d n=%0d mode=%0d e=%0d got %0d expected %0d",
                   it, n, mode, e, v, exp_count(e, n, auto_mode, 32'd0));
        end
        n_checks++;
        if (IRQ !== exp_irq(e, n, auto_mode, im)) begin
          n_fail++;
          $display("[TB] FAIL rand_irq it=%0d n=%0d mode=%0d im=%0d e=%0d got %b expected %b",
                   it, n, mode, im, e, IRQ, exp_irq(e, n, auto_mode, im));
        end
        peek(A_CTRL, v);
        n_checks++;
        if (v !== exp_ctrl(e, n, auto_mode, ctrl_val)) begin
          n_fail++;
          $display("[TB] FAIL rand_ctrl it=%0d n=%0d mode=%0d e=%0d got %h expected %h",
                   it, n, mode, e, v, exp_ctrl(e, n, auto_mode, ctrl_val));
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    WE     = 1'b0;
    Addr   = A_CTRL;
    byteen = 4'hF;
    Din    = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_pause_restart();
    test_preset_zero();
    test_collisions();
    test_edge_cases();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
